// File: rtl/ps2_key_ctrl.sv
// ps2_key_ctrl: drains the PS/2 receiver FIFO one byte at a time, folds the
// E0 (extended) and F0 (break) prefixes into single key events, and hands
// each event to the consumer on a valid/ready handshake. It also tracks the
// currently held key and counts non-repeat presses.
module ps2_key_ctrl (
   input  logic       clk,
   input  logic       clrn,
   input  logic [7:0] rx_data,
   input  logic       rx_ready,
   input  logic       rx_overflow,
   output logic       rx_nextdata_n,
   output logic       evt_valid,
   input  logic       evt_ready,
   output logic [7:0] evt_code,
   output logic       evt_ext,
   output logic       evt_break,
   output logic       evt_repeat,
   output logic [7:0] active_code,
   output logic       active_ext,
   output logic [7:0] press_count,
   output logic       err_overflow
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      POP    = 2'd1,
      SETTLE = 2'd2
   } state_t;

   localparam logic [7:0] CODE_EXT = 8'hE0;
   localparam logic [7:0] CODE_BRK = 8'hF0;

   state_t     state_q;
   logic [7:0] byte_q;
   logic       ext_pend_q;
   logic       brk_pend_q;
   logic       nextdata_n_q;
   logic       evt_valid_q;
   logic [7:0] evt_code_q;
   logic       evt_ext_q;
   logic       evt_break_q;
   logic       evt_repeat_q;
   logic [7:0] active_code_q;
   logic       active_ext_q;
   logic [7:0] press_count_q;
   logic       err_overflow_q;

   logic       is_ctrl_d;
   logic       key_match_d;
   logic       is_repeat_d;
   logic [7:0] press_count_d;

   // Classify the captured byte against the held key.
   always_comb begin
      // NOTE: every signal gets a default before any branch so no latch is inferred.
      is_ctrl_d     = 1'b0;
      key_match_d   = 1'b0;
      is_repeat_d   = 1'b0;
      press_count_d = press_count_q + 8'd1;
      if (byte_q inside {8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF, 8'hE1}) begin
         is_ctrl_d = 1'b1;
      end
      key_match_d = (byte_q == active_code_q) && (ext_pend_q == active_ext_q);
      // A repeat needs a held key; 00 in active_code means nothing is held.
      is_repeat_d = !brk_pend_q && key_match_d && (active_code_q != 8'h00);
   end

   // Pop/decode sequencer with registered outputs and event handshake.
   always_ff @(posedge clk or posedge clrn) begin
      if (clrn) begin
         state_q        <= IDLE;
         byte_q         <= 8'h00;
         ext_pend_q     <= 1'b0;
         brk_pend_q     <= 1'b0;
         nextdata_n_q   <= 1'b1;
         evt_valid_q    <= 1'b0;
         evt_code_q     <= 8'h00;
         evt_ext_q      <= 1'b0;
         evt_break_q    <= 1'b0;
         evt_repeat_q   <= 1'b0;
         active_code_q  <= 8'h00;
         active_ext_q   <= 1'b0;
         press_count_q  <= 8'h00;
         err_overflow_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register sees pre-edge values.
         if (rx_overflow) begin
            err_overflow_q <= 1'b1;
         end
         if (evt_valid_q && evt_ready) begin
            evt_valid_q <= 1'b0;
         end
         case (state_q)
            IDLE: begin
               // Holding off while an event is pending leaves back-pressure in the FIFO.
               if (rx_ready && !evt_valid_q) begin
                  byte_q       <= rx_data;
                  nextdata_n_q <= 1'b0;
                  state_q      <= POP;
               end
            end
            POP: begin
               nextdata_n_q <= 1'b1;
               state_q      <= SETTLE;
               if (byte_q == CODE_EXT) begin
                  ext_pend_q <= 1'b1;
               end else if (byte_q == CODE_BRK) begin
                  brk_pend_q <= 1'b1;
               end else begin
                  ext_pend_q <= 1'b0;
                  brk_pend_q <= 1'b0;
                  if (!is_ctrl_d) begin
                     evt_valid_q  <= 1'b1;
                     evt_code_q   <= byte_q;
                     evt_ext_q    <= ext_pend_q;
                     evt_break_q  <= brk_pend_q;
                     evt_repeat_q <= is_repeat_d;
                     if (!brk_pend_q) begin
                        if (!is_repeat_d) begin
                           press_count_q <= press_count_d;
                           active_code_q <= byte_q;
                           active_ext_q  <= ext_pend_q;
                        end
                     end else if (key_match_d) begin
                        active_code_q <= 8'h00;
                        active_ext_q  <= 1'b0;
                     end
                  end
               end
            end
            SETTLE: begin
               // Give the FIFO one cycle to present its next head and rx_ready.
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign rx_nextdata_n = nextdata_n_q;
   assign evt_valid     = evt_valid_q;
   assign evt_code      = evt_code_q;
   assign evt_ext       = evt_ext_q;
   assign evt_break     = evt_break_q;
   assign evt_repeat    = evt_repeat_q;
   assign active_code   = active_code_q;
   assign active_ext    = active_ext_q;
   assign press_count   = press_count_q;
   assign err_overflow  = err_overflow_q;

endmodule

// File: doc/ps2_key_ctrl.md
# ps2_key_ctrl

Sequencing controller between the PS/2 receiver FIFO and keyboard consumers (seven-segment display, ASCII decoder, counters). It drains the receiver with the `ready`/`nextdata_n` pop handshake and assembles prefix bytes (`E0` extended, `F0` break) into single key events. Each event goes out on a valid/ready handshake with back-pressure into the FIFO. It also tracks the currently held key and a press counter.

## Interface
- No parameters.
- `clk` in 1: system clock; all state updates on the rising edge.
- `clrn` in 1: reset, asynchronous, active-high.
- `rx_data` in 8: FIFO head byte, valid while `rx_ready`=1.
- `rx_ready` in 1: FIFO non-empty.
- `rx_overflow` in 1: receiver FIFO overflow flag.
- `rx_nextdata_n` out 1: pop strobe, active-low, registered, one cycle per pop.
- `evt_valid` out 1: key event available.
- `evt_ready` in 1: consumer accepts event.
- `evt_code` out 8: scan code of event.
- `evt_ext` out 1: event carried `E0` prefix.
- `evt_break` out 1: 1 = release, 0 = press.
- `evt_repeat` out 1: press is a typematic repeat of the held key.
- `active_code` out 8: code of currently held key, `00` if none.
- `active_ext` out 1: ext flag of held key.
- `press_count` out 8: count of non-repeat presses.
- `err_overflow` out 1: sticky, set when `rx_overflow`=1 is sampled.

## Operation
- Reset values:
  - `rx_nextdata_n`=1.
  - All other outputs 0.
  - `ext_pend`=0, `brk_pend`=0.
  - State IDLE.
- FSM states: IDLE, POP, SETTLE.
  - IDLE: if `rx_ready`=1 and `evt_valid`=0, capture `rx_data` into `byte_r`, drive `rx_nextdata_n`<=0 and go to POP. Otherwise hold.
  - POP: `rx_nextdata_n`<=1, decode `byte_r`, go to SETTLE.
  - SETTLE: one idle cycle so the FIFO head and `rx_ready` update, then go to IDLE.
- Decode rules (applied in POP):
  - `E0`: set `ext_pend`; no event.
  - `F0`: set `brk_pend`; no event.
  - `AA`, `FA`, `FE`, `EE`, `00`, `FF`, `E1`: control/error bytes. Clear both pending flags; no event.
  - Any other byte: load event.
    - `evt_code`=byte, `evt_ext`=`ext_pend`, `evt_break`=`brk_pend`.
    - `evt_valid`<=1.
    - Clear both pending flags.
- Press event (`brk_pend`=0):
  - If byte==`active_code` and `ext_pend`==`active_ext` and `active_code`!=0: `evt_repeat`=1, `press_count` unchanged.
  - Otherwise: `evt_repeat`=0, `press_count`<=`press_count`+1 (8-bit wrap, `FF`->`00`), `active_code`<=byte, `active_ext`<=`ext_pend`.
- Release event:
  - `evt_repeat`=0.
  - If code and ext match the held key, `active_code`<=`00` and `active_ext`<=0. Otherwise the held key is unchanged.
- Event handshake:
  - Event fields are held stable while `evt_valid`=1.
  - `evt_valid` clears on the edge where `evt_valid`=1 and `evt_ready`=1.
  - No pop occurs while `evt_valid`=1; the FIFO absorbs back-pressure.
- `err_overflow`: set on any edge with `rx_overflow`=1; cleared only by `clrn`.
- Reset mid-operation (any state, including POP with `rx_nextdata_n` low):
  - Immediate return to reset values.
  - A partial prefix sequence is discarded.

## Timing
- Byte at FIFO head in cycle n (`rx_ready`=1, state IDLE, no pending event):
  - `rx_nextdata_n` low during cycle n+1 only.
  - `evt_valid` high from cycle n+2.
  - Next byte sampled no earlier than cycle n+3.
- Throughput: 3 cycles per byte at most.
  - Make code: 1 byte.
  - Break code: 2 bytes.
  - Extended break: 3 bytes.
- `evt_ready` may be held high constantly. `evt_valid` is then high exactly one cycle per event.
- `press_count`, `active_code` and `active_ext` update on the same edge that raises `evt_valid`.

## Test plan
- Single press: FIFO holds `1C` -> one `rx_nextdata_n` low pulse, then `evt_valid` with code `1C`, ext 0, break 0, repeat 0; `press_count`=1, `active_code`=`1C`.
- Press/release: `1C`, `F0`, `1C` with `evt_ready`=1 -> two events (break 0 then break 1), 3 pops, final `active_code`=`00`, `press_count`=1.
- Extended release: `E0`, `75`, `E0`, `F0`, `75` -> events {`75`, ext 1, break 0} and {`75`, ext 1, break 1}, 5 pops, `active_ext`=0.
- Typematic/back-pressure: `1C`, `1C`, `1C` with `evt_ready`=0 for 20 cycles -> first event held stable, exactly 1 pop until accepted. After release: events 2 and 3 have repeat=1; `press_count` stays 1.
- Counter wrap and control bytes: 256 distinct press/release pairs -> `press_count`=`00`. An interleaved `AA` after `F0` clears the break prefix, and the following `1C` is a press.
- Overflow and reset: pulse `rx_overflow` -> `err_overflow`=1 sticky. Assert `clrn` during POP -> `rx_nextdata_n`=1 and all outputs 0 immediately.
